// File: rtl/cmm_sfifo_rd_skid_if.sv
// rtl/cmm_sfifo_rd_skid_if.sv - upstream FIFO read port and downstream valid/ready stream bundle
interface cmm_sfifo_rd_skid_if #(
    parameter int C_DW = 32
) ();
    logic            flush;
    logic            fifo_empty;
    logic [C_DW-1:0] fifo_dout;
    logic            fifo_pop;
    logic            m_valid;
    logic            m_ready;
    logic [C_DW-1:0] m_data;
    logic [1:0]      occ;

    // Skid block side
    modport slave (
        input  flush,
        input  fifo_empty,
        input  fifo_dout,
        output fifo_pop,
        output m_valid,
        input  m_ready,
        output m_data,
        output occ
    );

    // Environment side: FIFO model, consumer and flush control
    modport master (
        output flush,
        output fifo_empty,
        output fifo_dout,
        input  fifo_pop,
        input  m_valid,
        output m_ready,
        input  m_data,
        input  occ
    );
endinterface

// File: rtl/cmm_sfifo_rd_skid.sv
// rtl/cmm_sfifo_rd_skid.sv - two-entry registered skid buffer on a zero-latency FIFO read port
module cmm_sfifo_rd_skid #(
    parameter int C_DW = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    cmm_sfifo_rd_skid_if.slave   bus
);

    // Entry 0 is the head presented downstream, entry 1 the skid slot.
    logic [C_DW-1:0] entry0;
    logic [C_DW-1:0] entry1;
    logic [1:0]      cnt;
    logic            pop;
    logic            xfer;

    // Pop decision depends only on local state, never on m_ready, so the
    // upstream read strobe carries no combinational path from the consumer.
    // rst is folded in so the strobe drops immediately while reset is held.
    assign pop  = ~rst & ~bus.fifo_empty & ~bus.flush & ~cnt[1];

    // A flush cycle swallows the consumer handshake: nothing is transferred.
    assign xfer = (cnt != 2'd0) & bus.m_ready & ~bus.flush;

    assign bus.fifo_pop = pop;
    assign bus.m_valid  = (cnt != 2'd0);
    assign bus.m_data   = entry0;
    assign bus.occ      = cnt;

    // Occupancy: flush empties the buffer, otherwise add pops and subtract transfers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= 2'd0;
        end else if (bus.flush) begin
            cnt <= 2'd0;
        end else begin
            cnt <= cnt + {1'b0, pop} - {1'b0, xfer};
        end
    end

    // Entry data: capture popped word into the first free slot, or shift the
    // tail forward when the head leaves; data registers carry no reset.
    always_ff @(posedge clk) begin
        case ({pop, xfer})
            2'b10: begin
                if (cnt == 2'd0) begin
                    entry0 <= bus.fifo_dout;
                end else begin
                    entry1 <= bus.fifo_dout;
                end
            end
            2'b11: begin
                entry0 <= bus.fifo_dout;
            end
            2'b01: begin
                if (cnt == 2'd2) begin
                    entry0 <= entry1;
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: doc/cmm_sfifo_rd_skid.md
CMM_SFIFO_RD_SKID -- requirements
Module: cmm_sfifo_rd_skid

Interface
REQ-001 SHALL have parameter C_DW, default 32: data width, matching the data width of the upstream synchronous FIFO.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-004 SHALL have port flush, input, 1 bit: synchronous discard of all buffered data.
REQ-005 SHALL have port fifo_empty, input, 1 bit: upstream FIFO empty flag.
REQ-006 SHALL have port fifo_dout, input, C_DW bits: upstream FIFO read data, zero read delay, valid at the head entry whenever fifo_empty=0.
REQ-007 SHALL have port fifo_pop, output, 1 bit: upstream FIFO read strobe.
REQ-008 SHALL have port m_valid, output, 1 bit: downstream data valid.
REQ-009 SHALL have port m_ready, input, 1 bit: downstream ready.
REQ-010 SHALL have port m_data, output, C_DW bits: downstream data.
REQ-011 SHALL have port occ, output, 2 bits: number of entries held in the skid buffer (0..2).

Function
REQ-012 SHALL hold a 2-entry buffer (entry0 = head, entry1 = tail) and an occupancy count cnt in the range 0..2.
REQ-013 SHALL drive fifo_pop = ~fifo_empty & ~flush & (cnt < 2), with no combinational path from m_ready to fifo_pop.
REQ-014 SHALL capture fifo_dout into the buffer on the same edge at which fifo_pop=1, with a capture latency of 0 cycles.
REQ-015 SHALL drive m_valid = (cnt != 0) and m_data = entry0, both directly from registers.
REQ-016 SHALL treat a beat as transferred on any edge where m_valid=1 and m_ready=1.
REQ-017 SHALL update cnt as cnt_next = cnt + pop - xfer, for the cases below.
REQ-017a pop only, cnt=0: write entry0.
REQ-017b pop only, cnt=1: write entry1.
REQ-017c xfer only, cnt=2: entry0 <= entry1.
REQ-017d pop and xfer, cnt=1: entry0 <= fifo_dout.
REQ-017e pop and xfer, cnt=2: cannot occur, because pop is blocked when cnt=2.
REQ-018 SHALL keep m_data stable while m_valid=1 and m_ready=0.
REQ-019 SHALL preserve ordering: beats leave in the exact order they were popped, with no loss or duplication.
REQ-020 SHALL never assert fifo_pop while fifo_empty=1 (no underflow).
REQ-021 SHALL, on flush=1, set cnt to 0 at the next edge, take fifo_pop=0 in that cycle, and ignore m_ready in that cycle (no transfer counted).
REQ-022 SHALL drive occ = cnt.
REQ-023 SHALL, in steady state with fifo_empty=0 and m_ready=1, sustain 1 beat per cycle after a 1-cycle fill (m_valid rises one cycle after the first pop).
REQ-024 SHALL hold the entry data registers without reset; only the control state is reset.

Reset
REQ-025 SHALL, while rst=1, force cnt=0, giving m_valid=0, occ=0 and fifo_pop=0 immediately (asynchronously).
REQ-026 SHALL, on deassertion of rst, resume normal operation at the first rising clk edge with rst=0.
REQ-027 SHALL, on rst asserted mid-transfer, drop all buffered beats; upstream FIFO state is unaffected by this block.

Verification
REQ-028 Reset: rst=1 with fifo_empty=0 -> fifo_pop=0, m_valid=0, occ=0; after release, fifo_pop=1 in the first cycle.
REQ-029 Streaming: FIFO holds A,B,C,D and m_ready=1 -> m_data = A,B,C,D on 4 consecutive cycles starting 1 cycle after the first pop; occ stays 1.
REQ-030 Backpressure: m_ready=0 with 5 words in the FIFO -> exactly 2 pops, then occ=2 and fifo_pop=0; m_data holds the first word; raising m_ready drains in order with no gap.
REQ-031 Simultaneous pop and transfer at cnt=1 -> occ stays 1 and m_data advances to the newly popped word on the same edge.
REQ-032 Flush at occ=2 with fifo_empty=0 -> next cycle occ=0, m_valid=0; no pop during the flush cycle; popping resumes the cycle after.
REQ-033 Empty upstream: fifo_empty=1 for 10 cycles with occ=0 -> fifo_pop=0 and m_valid=0 throughout.
